// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the RV64M multiply/divide unit.
package mul_div_unit_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned ITERATIONS = 64;
  localparam int unsigned CNT_W      = 7;
  localparam int unsigned RD_W       = 5;

  // RV64M funct3 encodings
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  function automatic logic is_mul(op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/mul_div_sign_fix.sv
// Combinational sign handling: operand magnitudes on entry, sign correction and
// result selection on exit.
module mul_div_sign_fix
  import mul_div_unit_pkg::*;
(
  input  op_e              op,
  input  logic [XLEN-1:0]  operand_a,
  input  logic [XLEN-1:0]  operand_b,
  output logic [XLEN-1:0]  abs_a,
  output logic [XLEN-1:0]  abs_b,
  output logic             neg_a,
  output logic             neg_b,
  input  op_e              op_q,
  input  logic [XLEN-1:0]  acc_hi,
  input  logic [XLEN-1:0]  acc_lo,
  input  logic             res_neg_a,
  input  logic             res_neg_b,
  input  logic             b_zero,
  output logic [XLEN-1:0]  result
);

  logic            signed_a;
  logic            signed_b;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0] quo_fixed;
  logic [XLEN-1:0] rem_fixed;

  // Magnitudes and sign flags of the incoming operands
  always_comb begin
    signed_a = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    signed_b = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    neg_a    = signed_a & operand_a[XLEN-1];
    neg_b    = signed_b & operand_b[XLEN-1];
    abs_a    = neg_a ? -operand_a : operand_a;
    abs_b    = neg_b ? -operand_b : operand_b;
  end

  // Sign correction and result selection; divide-by-zero forces an all-ones quotient
  always_comb begin
    prod       = {acc_hi, acc_lo};
    prod_fixed = (res_neg_a ^ res_neg_b) ? -prod : prod;
    quo_fixed  = b_zero ? '1 : ((res_neg_a ^ res_neg_b) ? -acc_lo : acc_lo);
    rem_fixed  = res_neg_a ? -acc_hi : acc_hi;
    result     = '0;
    case (op_q)
      OP_MUL:                       result = prod_fixed[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fixed[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quo_fixed;
      OP_REM, OP_REMU:              result = rem_fixed;
      default:                      result = '0;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide unit: one radix-2 step per cycle, fixed latency.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  input  logic [RD_W-1:0] rdIn,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rdOut
);

  state_e            state;
  state_e            state_next;
  logic [CNT_W-1:0]  count;
  op_e               op_in;
  op_e               op_q;
  logic [RD_W-1:0]   rd_q;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic              neg_a;
  logic              neg_b;
  logic              b_zero;
  logic [XLEN-1:0]   result_q;
  logic [RD_W-1:0]   rd_out_q;

  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              in_neg_a;
  logic              in_neg_b;
  logic [XLEN-1:0]   fix_result;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic              iter_done;

  assign op_in     = op_e'(op);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign result    = result_q;
  assign rdOut     = rd_out_q;
  assign iter_done = (count == CNT_W'(ITERATIONS));

  mul_div_sign_fix u_sign_fix (
    .op        (op_in),
    .operand_a (operandA),
    .operand_b (operandB),
    .abs_a     (abs_a),
    .abs_b     (abs_b),
    .neg_a     (in_neg_a),
    .neg_b     (in_neg_b),
    .op_q      (op_q),
    .acc_hi    (acc_hi),
    .acc_lo    (acc_lo),
    .res_neg_a (neg_a),
    .res_neg_b (neg_b),
    .b_zero    (b_zero),
    .result    (fix_result)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; CALC spans 65 cycles (64 steps plus the exit cycle) to give the fixed latency
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (iter_done) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One shift-add or restoring-subtract step; acc_hi/acc_lo hold product or remainder/quotient
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[XLEN-1:0] - opnd;
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      b_zero   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op_in;
            rd_q   <= rdIn;
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            b_zero <= (operandB == '0);
            count  <= '0;
            acc_hi <= '0;
            if (is_mul(op_in)) begin
              opnd   <= abs_a;
              acc_lo <= abs_b;
            end else begin
              opnd   <= abs_b;
              acc_lo <= abs_a;
            end
          end
        end
        CALC: begin
          if (!iter_done) begin
            count <= count + 1'b1;
            if (is_mul(op_q)) begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
            end else if (div_ge) begin
              acc_hi <= div_diff;
              acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
            end
          end
        end
        FIX: begin
          result_q <= fix_result;
          rd_out_q <= rd_q;
        end
        default: ;
      endcase
    end
  end

endmodule
